// File: rtl/cpu_port_pkg.sv
// Shared constants for the 6510-style on-chip I/O port.
// Addresses, reset values and the indices of the bits that fade when undriven.
package cpu_port_pkg;

  localparam logic       ADDR_DDR  = 1'b0;
  localparam logic       ADDR_DAT  = 1'b1;
  localparam logic [7:0] DDR_RESET = 8'h00;
  localparam logic [7:0] DAT_RESET = 8'h00;
  localparam int         FADE_BITS [2] = '{7, 6};

endpackage

// File: rtl/cpu_port_fade.sv
// Single-bit fade model: an undriven bit holds its last driven level for
// FADE_CYCLES phi0 cycles, then decays to 0.
module cpu_port_fade #(
  parameter int FADE_CYCLES = 350000
) (
  input  logic phi0,
  input  logic reset,
  input  logic drive,
  input  logic dat_bit,
  output logic fade_val
);

  // A zero-length fade still needs a one-bit counter to stay legal.
  localparam int CW = (FADE_CYCLES > 0) ? $clog2(FADE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(FADE_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          fade_q, fade_d;

  always_comb begin
    cnt_d  = cnt_q;
    fade_d = fade_q;
    if (drive) begin
      cnt_d  = CNT_LOAD;
      fade_d = dat_bit;
    end else if (cnt_q > CW'(1)) begin
      cnt_d = cnt_q - CW'(1);
    end else begin
      // Reaching zero, or already idle at zero after reset, forces the bit low.
      cnt_d  = '0;
      fade_d = 1'b0;
    end
  end

  always_ff @(posedge phi0 or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      fade_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      fade_q <= fade_d;
    end
  end

  assign fade_val = fade_q;

endmodule

// File: rtl/cpu_port.sv
// CPU I/O port at $0000 (DDR) / $0001 (data) with optional bit 6/7 fade.
// Build with CPU_PORT_FADE_EN defined to include the fade logic.
module cpu_port
  import cpu_port_pkg::*;
#(
  parameter int FADE_CYCLES = 350000
) (
  input  logic       phi0,
  input  logic       reset,
  input  logic       sel,
  input  logic       a0,
  input  logic       r_w,
  input  logic [7:0] d_in,
  output logic [7:0] d_out,
  output logic       d_oe,
  input  logic [7:0] port_in,
  output logic [7:0] port_out,
  output logic [7:0] port_dir
);

  logic [7:0] ddr_q, ddr_d;
  logic [7:0] dat_q, dat_d;
  logic [7:0] undriven;
  logic [7:0] port_rd;
  logic       wr_en;

  assign wr_en = sel & ~r_w;

  always_comb begin
    ddr_d = ddr_q;
    dat_d = dat_q;
    if (wr_en && a0 == ADDR_DDR) ddr_d = d_in;
    if (wr_en && a0 == ADDR_DAT) dat_d = d_in;
  end

  always_ff @(posedge phi0 or posedge reset) begin
    if (reset) begin
      ddr_q <= DDR_RESET;
      dat_q <= DAT_RESET;
    end else begin
      ddr_q <= ddr_d;
      dat_q <= dat_d;
    end
  end

`ifdef CPU_PORT_FADE_EN
  logic [1:0] fade_val;

  for (genvar i = 0; i < 2; i++) begin : g_fade
    cpu_port_fade #(.FADE_CYCLES(FADE_CYCLES)) u_fade (
      .phi0     (phi0),
      .reset    (reset),
      .drive    (ddr_q[FADE_BITS[i]]),
      .dat_bit  (dat_q[FADE_BITS[i]]),
      .fade_val (fade_val[i])
    );
  end

  always_comb begin
    undriven = port_in;
    for (int i = 0; i < 2; i++) undriven[FADE_BITS[i]] = fade_val[i];
  end
`else
  always_comb begin
    undriven = port_in;
  end
`endif

  assign port_rd  = (dat_q & ddr_q) | (undriven & ~ddr_q);
  assign d_oe     = sel & r_w;
  assign d_out    = d_oe ? ((a0 == ADDR_DDR) ? ddr_q : port_rd) : 8'h00;
  assign port_out = dat_q;
  assign port_dir = ddr_q;

endmodule

// File: tb/tb_cpu_port.sv
// Directed scoreboard bench for cpu_port with FADE_CYCLES=8.
module tb_cpu_port;

`ifdef CPU_PORT_FADE_EN
  localparam bit FADE = 1'b1;
`else
  localparam bit FADE = 1'b0;
`endif

  logic       phi0 = 1'b0;
  logic       reset = 1'b1;
  logic       sel = 1'b0;
  logic       a0 = 1'b0;
  logic       r_w = 1'b1;
  logic [7:0] d_in = 8'h00;
  logic [7:0] d_out;
  logic       d_oe;
  logic [7:0] port_in = 8'h00;
  logic [7:0] port_out;
  logic [7:0] port_dir;

  int errors = 0;
  int checks = 0;

  logic [8:0] exp_q [$];
  string      tag_q [$];

  logic [7:0] m_ddr = 8'h00;
  logic [7:0] m_dat = 8'h00;

  cpu_port #(.FADE_CYCLES(8)) dut (
    .phi0     (phi0),
    .reset    (reset),
    .sel      (sel),
    .a0       (a0),
    .r_w      (r_w),
    .d_in     (d_in),
    .d_out    (d_out),
    .d_oe     (d_oe),
    .port_in  (port_in),
    .port_out (port_out),
    .port_dir (port_dir)
  );

  always #5 phi0 = ~phi0;

  function automatic logic [7:0] exp_dat(input logic [7:0] ddr, input logic [7:0] dat,
                                         input logic [7:0] pin, input logic [1:0] fv76);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) begin
      if (ddr[b])              r[b] = dat[b];
      else if (b >= 6 && FADE) r[b] = fv76[b-6];
      else                     r[b] = pin[b];
    end
    return r;
  endfunction

  task automatic chk9(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk();
    logic [8:0] e;
    string      t;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk9(t, {d_oe, d_out}, e);
  endtask

  // All tasks start #1 after a rising edge and end #1 after the next one.
  task automatic wr(input logic adr, input logic [7:0] val, input string tag);
    sel = 1'b1; r_w = 1'b0; a0 = adr; d_in = val;
    exp_q.push_back({1'b0, 8'h00});
    tag_q.push_back({tag, "_wr_bus"});
    #2 pop_chk();
    @(posedge phi0); #1;
    sel = 1'b0; r_w = 1'b1;
    if (adr) m_dat = val; else m_ddr = val;
    checks++;
    assert (port_dir === m_ddr && port_out === m_dat) else begin
      errors++;
      $error("FAIL %s_regs observed=%h/%h expected=%h/%h", tag, port_dir, port_out, m_ddr, m_dat);
    end
  endtask

  task automatic rd(input logic adr, input logic [7:0] exp, input string tag);
    sel = 1'b1; r_w = 1'b1; a0 = adr;
    exp_q.push_back({1'b1, exp});
    tag_q.push_back(tag);
    #2 pop_chk();
    @(posedge phi0); #1;
    sel = 1'b0;
  endtask

  initial begin
    port_in = 8'hA5;
    #3;
    chk9("reset_idle_bus", {d_oe, d_out}, 9'h000);
    checks++;
    assert (port_dir === 8'h00 && port_out === 8'h00) else begin
      errors++;
      $error("FAIL reset_regs observed=%h/%h expected=00/00", port_dir, port_out);
    end
    @(posedge phi0); #1;
    reset = 1'b0;
    @(posedge phi0); #1;

    rd(1'b0, 8'h00, "rst_rd_ddr");
    rd(1'b1, exp_dat(8'h00, 8'h00, 8'hA5, 2'b00), "rst_rd_dat");

    port_in = 8'hFF;
    wr(1'b0, 8'h2F, "w_ddr_2f");
    wr(1'b1, 8'h37, "w_dat_37");
    rd(1'b0, 8'h2F, "rd_ddr_2f");
    rd(1'b1, exp_dat(8'h2F, 8'h37, 8'hFF, 2'b00), "rd_dat_mix");

    // Fade of a released 11 pattern.
    port_in = 8'h15;
    wr(1'b0, 8'hC0, "f1_ddr");
    wr(1'b1, 8'hC0, "f1_dat");
    rd(1'b1, exp_dat(8'hC0, 8'hC0, 8'h15, 2'b11), "f1_driven");
    wr(1'b0, 8'h00, "f1_rel");
    for (int c = 1; c <= 10; c++)
      rd(1'b1, exp_dat(8'h00, 8'hC0, 8'h15, (c <= 8) ? 2'b11 : 2'b00),
         $sformatf("f1_cyc%0d", c));

    // Re-drive mid-countdown with dat=0x40, then a fresh full fade.
    port_in = 8'h2A;
    wr(1'b0, 8'hC0, "f2_ddr");
    wr(1'b0, 8'h00, "f2_rel");
    rd(1'b1, exp_dat(8'h00, 8'hC0, 8'h2A, 2'b11), "f2_cyc1");
    wr(1'b1, 8'h40, "f2_dat40");
    rd(1'b1, exp_dat(8'h00, 8'h40, 8'h2A, 2'b11), "f2_cyc3_dat_ignored");
    wr(1'b0, 8'hC0, "f2_redrive");
    rd(1'b1, exp_dat(8'hC0, 8'h40, 8'h2A, 2'b01), "f2_redriven");
    wr(1'b0, 8'h00, "f2_rel2");
    for (int c = 1; c <= 10; c++)
      rd(1'b1, exp_dat(8'h00, 8'h40, 8'h2A, (c <= 8) ? 2'b01 : 2'b00),
         $sformatf("f2_cyc%0d", c));

    // Reset during a countdown.
    port_in = 8'hC0;
    wr(1'b1, 8'hC0, "f3_dat");
    wr(1'b0, 8'hC0, "f3_ddr");
    rd(1'b1, exp_dat(8'hC0, 8'hC0, 8'hC0, 2'b11), "f3_driven");
    wr(1'b0, 8'h00, "f3_rel");
    rd(1'b1, exp_dat(8'h00, 8'hC0, 8'hC0, 2'b11), "f3_cyc1");
    rd(1'b1, exp_dat(8'h00, 8'hC0, 8'hC0, 2'b11), "f3_cyc2");
    #2 reset = 1'b1;
    #1;
    m_ddr = 8'h00; m_dat = 8'h00;
    checks++;
    assert (port_dir === 8'h00 && port_out === 8'h00) else begin
      errors++;
      $error("FAIL f3_async_rst observed=%h/%h expected=00/00", port_dir, port_out);
    end
    @(posedge phi0); #1;
    reset = 1'b0;
    for (int c = 1; c <= 9; c++)
      rd(1'b1, exp_dat(8'h00, 8'h00, 8'hC0, 2'b00), $sformatf("f3_post%0d", c));
    rd(1'b0, 8'h00, "f3_ddr_zero");

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
